// File: rtl/div_result_arbiter.sv
// Round-robin arbiter that feeds divider lane results into one registered output stage,
// which drains into the shared result FIFO under its not-full backpressure.
module div_result_arbiter #(
    parameter int DATA_WIDTH  = 65,
    parameter int NUM_REQ     = 4,
    parameter int LOG_NUM_REQ = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_valid_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    input  logic                          fifo_nfull_i,
    output logic [LOG_NUM_REQ-1:0]        grant_id_o,
    output logic [CNT_WIDTH-1:0]          word_cnt_o
);

    logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
    logic                   valid_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [LOG_NUM_REQ-1:0] grant_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [LOG_NUM_REQ-1:0] rr_ptr_reg;
    logic [LOG_NUM_REQ-1:0] rr_ptr_next;
    logic [LOG_NUM_REQ-1:0] winner;
    logic                   any_valid;
    logic                   drain;
    logic                   load_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A word may enter on the same edge the current one leaves, so no bubbles.
    assign drain   = valid_reg & fifo_nfull_i;
    assign load_en = ~valid_reg | fifo_nfull_i;

    always_comb begin
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_valid_i[LOG_NUM_REQ'(idx)]) begin
                any_valid = 1'b1;
                winner    = LOG_NUM_REQ'(idx);
            end
        end
    end

    assign rr_ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

    // Ready is forced low while reset is held, even though it is combinational.
    always_comb begin
        req_ready_o = '0;
        if (rst_n && any_valid && load_en) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            grant_reg  <= '0;
            cnt_reg    <= '0;
            rr_ptr_reg <= '0;
        end else begin
            if (drain) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load_en) begin
                if (any_valid) begin
                    valid_reg  <= 1'b1;
                    data_reg   <= req_word[winner];
                    grant_reg  <= winner;
                    rr_ptr_reg <= rr_ptr_next;
                end else begin
                    valid_reg <= 1'b0;
                end
            end
        end
    end

    assign fifo_valid_o = valid_reg;
    assign fifo_data_o  = data_reg;
    assign grant_id_o   = grant_reg;
    assign word_cnt_o   = cnt_reg;

endmodule
